decode_operand_stage: RTL and testbench
=======================================

Name: decode_operand_stage

Overview:
- Decode/operand-fetch stage sitting directly upstream of the ALU.
- Accepts 32-bit RV32I instructions from fetch over a valid/ready handshake.
- Decodes R-type (OP) and I-type (OP-IMM) ALU instructions and reads an internal 32-entry register file.
- Presents registered funct7/funct3/source1/source2 to the ALU, and accepts a writeback port from the downstream retire stage.

Parameters:
- XLEN, 32, datapath and register width; only 32 is supported by the decode.
- REG_RESET_VAL, 0, value loaded into x1..x31 on reset.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_instr  input  32  instruction word.
- out_valid  output  1  decoded operation held for the ALU.
- out_ready  input  1  downstream consumes the held operation.
- out_funct7  output  7  to ALU funct7.
- out_funct3  output  3  to ALU funct3.
- out_source1  output  XLEN  to ALU source1.
- out_source2  output  XLEN  to ALU source2.
- out_rd  output  5  destination register, carried to writeback.
- out_illegal  output  1  held instruction was not OP/OP-IMM.
- wb_en  input  1  register write enable.
- wb_rd  input  5  write address.
- wb_data  input  XLEN  write data.

Behaviour:
- Reset (async, reset_n=0):
  - out_valid=0; out_funct7, out_funct3, out_source1, out_source2, out_rd, out_illegal all 0.
  - x0..x31 set to REG_RESET_VAL; x0 always reads 0 regardless.
  - Reset mid-transfer discards the held operation; no stale out_valid after release.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Capture on the rising edge when in_valid && in_ready. Latency is 1 cycle: the instruction accepted at edge N is on the outputs after edge N.
  - If out_valid && out_ready && !in_valid, out_valid drops to 0.
  - While out_valid && !out_ready, all out_* signals hold stable and in_ready=0.
  - Back-to-back accept with out_ready=1 gives full throughput, one instruction per cycle.
- Decode (opcode = in_instr[6:0]; rs1=[19:15]; rs2=[24:20]; rd=[11:7]; funct3=[14:12]):
  - 0110011 (OP):
    - funct7 = instr[31:25]
    - source1 = rf[rs1]
    - source2 = rf[rs2]
  - 0010011 (OP-IMM):
    - source1 = rf[rs1]
    - source2 = sign-extended instr[31:20]
    - funct7 = instr[31:25] when funct3 is 001 or 101 (shifts, so SRAI keeps 0100000); otherwise funct7 = 0, so ADDI never becomes subtract.
  - Any other opcode:
    - out_illegal=1
    - funct7, funct3, source1, source2 and rd all forced to 0.
  - rd=0 is passed through unchanged; writeback of x0 is ignored.
- Register file:
  - Write on the rising edge when wb_en && wb_rd!=0.
  - Reads are combinational and are sampled at the capture edge.
  - A held output is never refreshed by later writes. Operands are frozen at capture.
- Simultaneous accept and writeback to the same source register: see Optional Feature.

Optional Feature:
- DECODE_WB_BYPASS_EN
  - Defined: when capturing, if wb_en && wb_rd!=0 && wb_rd==rs1 (or rs2, OP only), the captured source takes wb_data for that operand. Both operands are bypassed independently.
  - Undefined: the captured source takes the pre-write register value, and the register updates on the same edge. Hazard avoidance is then the caller's responsibility.

Test Plan:
- Reset, then write x1=2 and x2=1 via wb; send 0x002081B3 (add x3,x1,x2) with out_ready=1 → after 1 cycle: out_valid=1, funct7=0, funct3=0, source1=2, source2=1, rd=3.
- Send 0x402081B3 (sub x3,x1,x2) → funct7=0100000, source1=2, source2=1; ALU result 1.
- Send 0xFFF08193 (addi x3,x1,-1) → funct7=0, source2=0xFFFFFFFF. Then send 0x4010D193 (srai x3,x1,1) → funct7=0100000, funct3=101, source2=0x00000401.
- Hold out_ready=0 for 3 cycles after an accept while in_valid=1 → in_ready=0, outputs stable, second instruction is accepted only on the edge where out_ready=1.
- Send an instruction reading x5 in the same cycle as wb_en=1, wb_rd=5, wb_data=0xDEADBEEF (old x5=0) → source1=0xDEADBEEF with DECODE_WB_BYPASS_EN defined, 0 without. Also verify a write to x0 is ignored and x0 reads 0.
- Send 0x0000006F (jal) → out_illegal=1 with all other outputs 0. Assert reset_n=0 while out_valid=1 → out_valid=0 immediately, asynchronously.

Source files
------------

// File: rtl/decode_operand_stage.sv
// RV32I decode/operand-fetch stage for OP and OP-IMM, with a 32-entry register file
// and a one-entry output register. Optional macro DECODE_WB_BYPASS_EN forwards same-edge writeback data.
module decode_operand_stage #(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] REG_RESET_VAL = '0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_funct3,
    output logic [XLEN-1:0] out_source1,
    output logic [XLEN-1:0] out_source2,
    output logic [4:0]      out_rd,
    output logic            out_illegal,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    logic [XLEN-1:0] rf_q [32];
    logic [XLEN-1:0] rf_d [32];

    logic            valid_q, valid_d;
    logic [6:0]      funct7_q, funct7_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] src1_q, src1_d;
    logic [XLEN-1:0] src2_q, src2_d;
    logic [4:0]      rd_q, rd_d;
    logic            illegal_q, illegal_d;

    logic            accept;
    logic            wb_write;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_i;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign wb_write = wb_en && (wb_rd != 5'd0);

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign rd     = in_instr[11:7];
    assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

    // x0 is hardwired to zero on read; its storage entry is never written.
    always_comb begin
        rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
        rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_write && (wb_rd == rs1)) rs1_val = wb_data;
        if (wb_write && (wb_rd == rs2)) rs2_val = wb_data;
`endif
    end

    always_comb begin
        for (int i = 0; i < 32; i++) rf_d[i] = rf_q[i];
        if (wb_write) rf_d[wb_rd] = wb_data;
    end

    always_comb begin
        valid_d   = valid_q;
        funct7_d  = funct7_q;
        funct3_d  = funct3_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
        if (accept) begin
            valid_d   = 1'b1;
            funct7_d  = '0;
            funct3_d  = '0;
            src1_d    = '0;
            src2_d    = '0;
            rd_d      = '0;
            illegal_d = 1'b0;
            case (opcode)
                OPC_OP: begin
                    funct7_d = in_instr[31:25];
                    funct3_d = f3;
                    src1_d   = rs1_val;
                    src2_d   = rs2_val;
                    rd_d     = rd;
                end
                OPC_OP_IMM: begin
                    // Only shifts carry funct7; ADDI etc. must not look like SUB.
                    funct7_d = (f3 == 3'b001 || f3 == 3'b101) ? in_instr[31:25] : 7'd0;
                    funct3_d = f3;
                    src1_d   = rs1_val;
                    src2_d   = imm_i;
                    rd_d     = rd;
                end
                default: illegal_d = 1'b1;
            endcase
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= REG_RESET_VAL;
        end else begin
            for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            funct7_q  <= '0;
            funct3_q  <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            funct7_q  <= funct7_d;
            funct3_q  <= funct3_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_funct7  = funct7_q;
    assign out_funct3  = funct3_q;
    assign out_source1 = src1_q;
    assign out_source2 = src2_q;
    assign out_rd      = rd_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed bench for decode_operand_stage: decode, handshake stall, writeback hazard, reset.
module tb_decode_operand_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_funct7;
    logic [2:0]  out_funct3;
    logic [31:0] out_source1;
    logic [31:0] out_source2;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_ADDI = 32'hFFF08193;
    localparam logic [31:0] I_SRAI = 32'h4010D193;
    localparam logic [31:0] I_X5   = 32'h00028313; // addi x6,x5,0
    localparam logic [31:0] I_X0   = 32'h000003B3; // add x7,x0,x0
    localparam logic [31:0] I_JAL  = 32'h008000EF;

`ifdef DECODE_WB_BYPASS_EN
    localparam logic [31:0] EXP_HAZ = 32'hDEADBEEF;
`else
    localparam logic [31:0] EXP_HAZ = 32'h0;
`endif

    decode_operand_stage dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_funct7(out_funct7), .out_funct3(out_funct3),
        .out_source1(out_source1), .out_source2(out_source2),
        .out_rd(out_rd), .out_illegal(out_illegal),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [6:0] f7,
                           input logic [2:0] f3, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [4:0] rd, input logic ill);
        chk({tag, ".valid"},   32'(out_valid),   32'(vld));
        chk({tag, ".funct7"},  32'(out_funct7),  32'(f7));
        chk({tag, ".funct3"},  32'(out_funct3),  32'(f3));
        chk({tag, ".src1"},    out_source1,      s1);
        chk({tag, ".src2"},    out_source2,      s2);
        chk({tag, ".rd"},      32'(out_rd),      32'(rd));
        chk({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
    endtask

    task automatic edge_sample();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        #12;
        chk_out("reset", 1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clock) reset_n = 1'b1;

        @(negedge clock) begin wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd2; end
        @(negedge clock) begin wb_rd = 5'd2; wb_data = 32'd1; end
        @(negedge clock) wb_en = 1'b0;

        // Back-to-back stream at full throughput.
        out_ready = 1'b1; in_valid = 1'b1; in_instr = I_ADD;
        edge_sample(); chk_out("add", 1'b1, 7'h00, 3'd0, 32'd2, 32'd1, 5'd3, 1'b0);
        @(negedge clock) in_instr = I_SUB;
        edge_sample(); chk_out("sub", 1'b1, 7'h20, 3'd0, 32'd2, 32'd1, 5'd3, 1'b0);
        chk("sub.alu", out_source1 - out_source2, 32'd1);
        @(negedge clock) in_instr = I_ADDI;
        edge_sample(); chk_out("addi", 1'b1, 7'h00, 3'd0, 32'd2, 32'hFFFFFFFF, 5'd3, 1'b0);
        @(negedge clock) in_instr = I_SRAI;
        edge_sample(); chk_out("srai", 1'b1, 7'h20, 3'd5, 32'd2, 32'h00000401, 5'd3, 1'b0);
        @(negedge clock) in_valid = 1'b0;
        edge_sample();
        chk("drain.valid", 32'(out_valid), 32'd0);
        chk("drain.in_ready", 32'(in_ready), 32'd1);

        // Stall: held ADD must not move, nor pick up a write to x1.
        @(negedge clock) begin in_valid = 1'b1; in_instr = I_ADD; out_ready = 1'b0; end
        edge_sample(); chk_out("stall.acc", 1'b1, 7'h00, 3'd0, 32'd2, 32'd1, 5'd3, 1'b0);
        @(negedge clock) begin in_instr = I_SUB; wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h55; end
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            chk("stall.in_ready", 32'(in_ready), 32'd0);
            chk_out("stall.hold", 1'b1, 7'h00, 3'd0, 32'd2, 32'd1, 5'd3, 1'b0);
            @(negedge clock);
            if (i == 0) wb_data = 32'd2;
            if (i == 1) wb_en = 1'b0;
        end
        out_ready = 1'b1;
        #1 chk("stall.release_ready", 32'(in_ready), 32'd1);
        edge_sample(); chk_out("stall.next", 1'b1, 7'h20, 3'd0, 32'd2, 32'd1, 5'd3, 1'b0);

        // Same-edge writeback to a source register.
        @(negedge clock) begin in_instr = I_X5; wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; end
        edge_sample(); chk_out("haz", 1'b1, 7'h00, 3'd0, EXP_HAZ, 32'd0, 5'd6, 1'b0);
        @(negedge clock) wb_en = 1'b0;
        edge_sample(); chk_out("haz.after", 1'b1, 7'h00, 3'd0, 32'hDEADBEEF, 32'd0, 5'd6, 1'b0);

        // x0 stays zero even when written (same edge and later).
        @(negedge clock) begin in_instr = I_X0; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234; end
        edge_sample(); chk_out("x0.same", 1'b1, 7'h00, 3'd0, 32'd0, 32'd0, 5'd7, 1'b0);
        @(negedge clock) wb_en = 1'b0;
        edge_sample(); chk_out("x0.after", 1'b1, 7'h00, 3'd0, 32'd0, 32'd0, 5'd7, 1'b0);

        @(negedge clock) in_instr = I_JAL;
        edge_sample(); chk_out("jal", 1'b1, 7'h00, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1);

        // Async reset while holding a valid operation.
        @(negedge clock) begin in_valid = 1'b0; out_ready = 1'b0; end
        edge_sample(); chk("pre_rst.valid", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.illegal", 32'(out_illegal), 32'd0);
        @(negedge clock) reset_n = 1'b1;
        edge_sample(); chk("rst.no_stale", 32'(out_valid), 32'd0);

        @(negedge clock) begin out_ready = 1'b1; in_valid = 1'b1; in_instr = I_ADD; end
        edge_sample(); chk_out("rst.rf", 1'b1, 7'h00, 3'd0, 32'd0, 32'd0, 5'd3, 1'b0);
        @(negedge clock) in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
